// File: rtl/bus_rr_arbiter_pkg.sv
// Shared constants, default widths and clog2 helper for the round-robin bus.
// No logic; no latency; no backpressure.
package bus_rr_arbiter_pkg;

    localparam logic ENABLE_      = 1'b0;
    localparam logic DISABLE_     = 1'b1;
    localparam logic READ         = 1'b1;
    localparam logic WRITE        = 1'b0;
    localparam logic RESET_ENABLE = 1'b1;

    localparam int DEF_NUM_M   = 4;
    localparam int DEF_NUM_S   = 8;
    localparam int DEF_ADDR_W  = 30;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int WDOG_W      = 10;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Rotating-priority encoder: first requester after own, wrapping; own itself ranks last.
// Latency: combinational. Backpressure: none.
// Requests are active-high here; vld is set when any master requests.
module bus_rr_pick
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M,
    localparam int OWN_W = (NUM_M > 1) ? clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [OWN_W-1:0] own,
    output logic [OWN_W-1:0] nxt,
    output logic             vld
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        nxt = own;
        vld = 1'b0;
        for (int d = NUM_M; d >= 1; d--) begin
            if (req[(int'(own) + d) % NUM_M]) begin
                nxt = OWN_W'((int'(own) + d) % NUM_M);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// N-master round-robin shared-bus controller with address decode and read-return mux; optional watchdog via BUS_TIMEOUT_EN.
// Latency: grant registered (1 cycle), decode/return combinational. Backpressure: masters wait on m_rdy_; a hung slave stalls unless the watchdog is built.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_M   = DEF_NUM_M,
    parameter int NUM_S   = DEF_NUM_S,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_M-1:0]          m_req_,
    output logic [NUM_M-1:0]          m_grnt_,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr,
    input  logic [NUM_M-1:0]          m_as_,
    input  logic [NUM_M-1:0]          m_rw,
    input  logic [NUM_M*DATA_W-1:0]   m_wr_data,
    output logic [DATA_W-1:0]         m_rd_data,
    output logic                      m_rdy_,
    output logic                      m_err,
    output logic [ADDR_W-1:0]         s_addr,
    output logic                      s_as_,
    output logic                      s_rw,
    output logic [DATA_W-1:0]         s_wr_data,
    output logic [NUM_S-1:0]          s_cs_,
    input  logic [NUM_S*DATA_W-1:0]   s_rd_data,
    input  logic [NUM_S-1:0]          s_rdy_
);

    localparam int OWN_W = (NUM_M > 1) ? clog2(NUM_M) : 1;
    localparam int SEL_W = clog2(NUM_S);

    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("bus_rr_arbiter: TIMEOUT out of range");
    end

    logic [OWN_W-1:0]  own;
    logic [OWN_W-1:0]  own_nxt;
    logic [OWN_W-1:0]  pick_own;
    logic              pick_vld;
    logic [SEL_W-1:0]  sel;
    logic              rdy_sel;
    logic [DATA_W-1:0] rd_sel;
    logic              wd_hit;

    bus_rr_pick #(.NUM_M(NUM_M)) u_pick (
        .req (~m_req_),
        .own (own),
        .nxt (pick_own),
        .vld (pick_vld)
    );

    // The owner keeps the bus while requesting; the grant parks when nobody asks.
    always_comb begin
        own_nxt = own;
        if (m_req_[own] != ENABLE_ && pick_vld)
            own_nxt = pick_own;
    end

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            own     <= '0;
            m_grnt_ <= ~NUM_M'(1);
        end else begin
            own     <= own_nxt;
            m_grnt_ <= ~(NUM_M'(1) << own_nxt);
        end
    end

    assign s_addr    = m_addr[int'(own)*ADDR_W +: ADDR_W];
    assign s_wr_data = m_wr_data[int'(own)*DATA_W +: DATA_W];
    assign s_as_     = m_as_[own];
    assign s_rw      = m_rw[own];

    assign sel     = s_addr[ADDR_W-1 -: SEL_W];
    assign rdy_sel = s_rdy_[sel];
    assign rd_sel  = s_rd_data[int'(sel)*DATA_W +: DATA_W];

`ifdef BUS_TIMEOUT_EN
    logic [WDOG_W-1:0] wd_cnt;

    // Fires only while the slave is still silent, so a genuine ready always wins.
    assign wd_hit = (s_as_ == ENABLE_) && (rdy_sel == DISABLE_) &&
                    (wd_cnt == WDOG_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE)
            wd_cnt <= '0;
        else if (s_as_ == DISABLE_ || rdy_sel == ENABLE_ || own_nxt != own || wd_hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        s_cs_     = '1;
        m_rd_data = '0;
        m_rdy_    = DISABLE_;
        if (s_as_ == ENABLE_) begin
            s_cs_[sel] = ENABLE_;
            if (wd_hit) begin
                m_rdy_ = ENABLE_;
            end else begin
                m_rd_data = rd_sel;
                m_rdy_    = rdy_sel;
            end
        end
    end

    assign m_err = wd_hit;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed and randomized checks of bus_rr_arbiter against a cycle-level reference model.
module tb_bus_rr_arbiter;

    localparam int NM = 4;
    localparam int NS = 8;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NM-1:0]    m_req_;
    logic [NM-1:0]    m_grnt_;
    logic [NM*AW-1:0] m_addr;
    logic [NM-1:0]    m_as_;
    logic [NM-1:0]    m_rw;
    logic [NM*DW-1:0] m_wr_data;
    logic [DW-1:0]    m_rd_data;
    logic             m_rdy_;
    logic             m_err;
    logic [AW-1:0]    s_addr;
    logic             s_as_;
    logic             s_rw;
    logic [DW-1:0]    s_wr_data;
    logic [NS-1:0]    s_cs_;
    logic [NS*DW-1:0] s_rd_data;
    logic [NS-1:0]    s_rdy_;

    int n_cmp = 0;
    int n_bad = 0;
    int own_m = 0;
    int cnt_m = 0;
    bit model_ok = 1'b0;

    bus_rr_arbiter #(
        .NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr), .m_as_(m_as_),
        .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
        .m_rdy_(m_rdy_), .m_err(m_err),
        .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .s_cs_(s_cs_), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bus outputs for the current inputs and the model's owner/counter.
    task automatic check_model();
        int            o;
        int            sel;
        logic [AW-1:0] a;
        logic          as_n;
        logic          rs;
        logic          to;
        logic [NM-1:0] eg;
        logic [NS-1:0] ecs;
        logic [DW-1:0] erd;
        logic          erdy;
        o    = own_m;
        a    = m_addr[o*AW +: AW];
        sel  = int'(a[AW-1 -: 3]);
        as_n = m_as_[o];
        rs   = s_rdy_[sel];
        to   = WD && !as_n && rs && (cnt_m == TO);
        eg   = ~(4'b0001 << o);
        ecs  = 8'hFF;
        if (!as_n) ecs[sel] = 1'b0;
        erd  = (as_n || to) ? '0 : s_rd_data[sel*DW +: DW];
        erdy = as_n ? 1'b1 : (to ? 1'b0 : rs);
        chk("grant", m_grnt_, eg);
        chk("s_addr", s_addr, a);
        chk("s_as_", s_as_, as_n);
        chk("s_rw", s_rw, m_rw[o]);
        chk("s_wr_data", s_wr_data, m_wr_data[o*DW +: DW]);
        chk("s_cs_", s_cs_, ecs);
        chk("m_rd_data", m_rd_data, erd);
        chk("m_rdy_", m_rdy_, erdy);
        chk("m_err", m_err, to);
    endtask

    task automatic model_update();
        int   nxt;
        bit   found;
        int   sel;
        logic as_n;
        logic rs;
        logic to;
        if (reset) begin
            own_m    = 0;
            cnt_m    = 0;
            model_ok = 1'b1;
        end else begin
            nxt   = own_m;
            found = 1'b0;
            if (m_req_[own_m]) begin
                for (int d = 1; d < NM; d++) begin
                    if (!found && !m_req_[(own_m + d) % NM]) begin
                        nxt   = (own_m + d) % NM;
                        found = 1'b1;
                    end
                end
            end
            sel  = int'(m_addr[own_m*AW + AW - 1 -: 3]);
            as_n = m_as_[own_m];
            rs   = s_rdy_[sel];
            to   = WD && !as_n && rs && (cnt_m == TO);
            if (as_n || !rs || nxt != own_m || to)
                cnt_m = 0;
            else
                cnt_m = cnt_m + 1;
            own_m = nxt;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (model_ok) check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input int m, input logic as_n, input logic rw,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        m_as_[m]             = as_n;
        m_rw[m]              = rw;
        m_addr[m*AW +: AW]   = a;
        m_wr_data[m*DW +: DW] = wd;
    endtask

    initial begin
        logic [NM-1:0] eg;
        logic [NS-1:0] rdy_v;
        logic          hit;
        reset     = 1'b1;
        m_req_    = '1;
        m_as_     = '1;
        m_rw      = '0;
        m_addr    = '0;
        m_wr_data = '0;
        s_rdy_    = '1;
        for (int s = 0; s < NS; s++) s_rd_data[s*DW +: DW] = DW'(s);

        // Reset and idle
        cycle();
        cycle();
        chk("rst_grant", m_grnt_, 4'b1110);
        chk("rst_cs", s_cs_, 8'hFF);
        chk("rst_rdy", m_rdy_, 1'b1);
        chk("rst_err", m_err, 1'b0);
        reset = 1'b0;

        // Masters 0 and 1 request; 0 drops after two cycles
        m_req_ = 4'b1100;
        cycle();
        cycle();
        chk("hold0", m_grnt_, 4'b1110);
        m_req_ = 4'b1101;
        cycle();
        chk("handover", m_grnt_, 4'b1101);
        cycle();
        cycle();
        chk("keep1", m_grnt_, 4'b1101);

        // All request, owner releases for one cycle after each grant
        reset  = 1'b1;
        m_req_ = '1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            eg = ~(4'b0001 << (k % NM));
            chk($sformatf("rot%0d", k), m_grnt_, eg);
            m_req_ = 4'(1 << (k % NM));
            cycle();
        end

        // Owner 1 reads slave 5
        m_req_ = 4'b1101;
        drive(1, 1'b0, 1'b1, {3'b101, 27'h0}, '0);
        s_rdy_ = ~8'h20;
        #1;
        chk("rd_cs", s_cs_, 8'b1101_1111);
        chk("rd_data", m_rd_data, 32'h0000_0005);
        chk("rd_rdy", m_rdy_, 1'b0);
        cycle();
        drive(1, 1'b1, 1'b1, {3'b101, 27'h0}, '0);
        s_rdy_ = '1;
        cycle();

        // Hung slave 3
        drive(1, 1'b0, 1'b1, {3'b011, 27'h0}, '0);
        for (int i = 0; i < 10; i++) begin
            #1;
            hit = WD && (i == 4 || i == 9);
            chk($sformatf("wd_err%0d", i), m_err, hit);
            chk($sformatf("wd_rdy%0d", i), m_rdy_, !hit);
            chk($sformatf("wd_rd%0d", i), m_rd_data, hit ? 32'h0 : 32'h3);
            cycle();
        end
        drive(1, 1'b1, 1'b1, {3'b011, 27'h0}, '0);
        cycle();

        // Reset while master 2 owns the bus mid-access
        m_req_ = 4'b1011;
        cycle();
        chk("own2", m_grnt_, 4'b1011);
        drive(2, 1'b0, 1'b0, {3'b110, 27'h0}, 32'hABCD_0123);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst2_grant", m_grnt_, 4'b1110);
        chk("rst2_cs", s_cs_, 8'hFF);
        chk("rst2_err", m_err, 1'b0);
        reset = 1'b0;
        drive(2, 1'b1, 1'b0, '0, '0);
        m_req_ = 4'b1110;
        drive(0, 1'b0, 1'b1, {3'b110, 27'h0}, '0);
        for (int i = 0; i < 6; i++) cycle();
        drive(0, 1'b1, 1'b1, '0, '0);
        cycle();

        // Randomized traffic checked every cycle by the model
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int m = 0; m < NM; m++) begin
                m_req_[m] = ($urandom_range(0, 4) == 0);
                m_as_[m]  = ($urandom_range(0, 3) == 0);
                m_rw[m]   = 1'($urandom);
                if ($urandom_range(0, 3) == 0) m_addr[m*AW +: AW] = AW'($urandom);
                m_wr_data[m*DW +: DW] = $urandom;
            end
            for (int s = 0; s < NS; s++) begin
                s_rd_data[s*DW +: DW] = $urandom;
                rdy_v[s] = ($urandom_range(0, 3) != 0);
            end
            s_rdy_ = rdy_v;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
